// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// shift_reg_pkg : shift-mode encodings and controller state type
// Rev 1.0
// ============================================================================
package shift_reg_pkg;

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_reg_univ_if.sv
`default_nettype none
// ============================================================================
// shift_reg_univ_if : parallel/serial data and START/BUSY/DONE handshake bundle
// Rev 1.0
// ============================================================================
interface shift_reg_univ_if #(
  parameter int N  = 16,
  parameter int CW = $clog2(N + 1)
);
  logic          load;
  logic [N-1:0]  data_in;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] amt;
  logic          sin;
  logic [N-1:0]  reg_q;
  logic          sout;
  logic          busy;
  logic          done;

  modport master (
    output load, data_in, start, mode, amt, sin,
    input  reg_q, sout, busy, done
  );

  modport slave (
    input  load, data_in, start, mode, amt, sin,
    output reg_q, sout, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/shift_reg_step.sv
`default_nettype none
// ============================================================================
// shift_reg_step : combinational single-bit shift in one of five modes
// Rev 1.0
// ============================================================================
module shift_reg_step
  import shift_reg_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] i_reg,
  input  logic [2:0]   i_mode,
  input  logic         i_sin,
  output logic [N-1:0] o_reg,
  output logic         o_bit
);

  always_comb begin
    o_reg = i_reg;
    o_bit = 1'b0;
    case (i_mode)
      MODE_LSL: begin o_reg = {i_reg[N-2:0], i_sin};     o_bit = i_reg[N-1]; end
      MODE_LSR: begin o_reg = {i_sin, i_reg[N-1:1]};     o_bit = i_reg[0];   end
      MODE_ASR: begin o_reg = {i_reg[N-1], i_reg[N-1:1]}; o_bit = i_reg[0];  end
      MODE_ROL: begin o_reg = {i_reg[N-2:0], i_reg[N-1]}; o_bit = i_reg[N-1]; end
      MODE_ROR: begin o_reg = {i_reg[0], i_reg[N-1:1]};  o_bit = i_reg[0];   end
      default:  ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
// shift_reg_univ : universal shift register with multi-cycle shift-by-AMT
// Rev 1.0
// ============================================================================
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int N  = 16,
  parameter int CW = $clog2(N + 1)
) (
  input  wire logic      clk,
  input  wire logic      a_clr,
  shift_reg_univ_if.slave bus
);

  localparam logic [CW-1:0] C_N   = CW'(N);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_reg;
  logic          r_sout;
  logic          r_done;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_mode;

  logic [N-1:0]  w_step_reg;
  logic          w_step_bit;
  logic [CW-1:0] w_amt_eff;
  logic          w_legal;
  logic          w_go;

  assign w_amt_eff = (bus.amt > C_N) ? C_N : bus.amt;
  assign w_legal   = (bus.mode <= MODE_ROR);

  shift_reg_step #(.N(N)) u_step (
    .i_reg  (r_reg),
    .i_mode (r_mode),
    .i_sin  (bus.sin),
    .o_reg  (w_step_reg),
    .o_bit  (w_step_bit)
  );

  always_comb begin
    w_next = r_state;
    w_go   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.load && bus.start && w_legal && (w_amt_eff != '0)) begin
          w_go   = 1'b1;
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.load || (r_cnt == C_ONE)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_clr) begin
    if (a_clr) begin
      r_state <= ST_IDLE;
      r_reg   <= '0;
      r_sout  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= MODE_LSL;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (bus.load) begin
          r_reg <= bus.data_in;
        end else if (w_go) begin
          r_mode <= bus.mode;
          r_cnt  <= w_amt_eff;
        end else if (bus.start) begin
          // Zero-length or illegal request still completes the handshake.
          r_done <= 1'b1;
        end
      end else if (bus.load) begin
        r_reg <= bus.data_in;
        r_cnt <= '0;
      end else begin
        r_reg  <= w_step_reg;
        r_sout <= w_step_bit;
        r_cnt  <= r_cnt - C_ONE;
        if (r_cnt == C_ONE) r_done <= 1'b1;
      end
    end
  end

  assign bus.reg_q = r_reg;
  assign bus.sout  = r_sout;
  assign bus.busy  = (r_state == ST_SHIFT);
  assign bus.done  = r_done;

endmodule
`default_nettype wire
